// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl
//   Sequencer for a serial-in/serial-out shift register. A parallel tx word
//   accepted on a valid/ready handshake is serialised onto si while se is high
//   for exactly WIDTH cycles. so is captured on the same edges, so the word
//   previously held in the register is returned as a parallel rx word on its
//   own valid/ready handshake.
//
//   Build option: define SHIFT_REG_CTRL_MSB_FIRST_EN to transmit/receive MSB
//   first. Default build is LSB first.
//
//   Ports:
//     clk       rising-edge clock
//     rstn      asynchronous active-low reset
//     tx_data   parallel word to shift in        tx_valid / tx_ready handshake
//     si, se    serial data and shift enable to the shift register
//     so        serial data from the shift register
//     rx_data   word shifted out of the register rx_valid / rx_ready handshake
//     busy      high while shifting or holding an rx word
module shift_reg_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             si,
  output logic             se,
  input  logic             so,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] rx_data_nxt;
  logic             se_nxt, si_nxt, rx_valid_nxt, busy_nxt;

  // Order-dependent helpers: the shadow is shifted so that the next bit to
  // transmit always sits at a fixed position; the accumulator fills from the
  // end that makes the first received bit land where it was first sent.
  logic [WIDTH-1:0] shadow_shift;
  logic [WIDTH-1:0] acc_in;
  logic             first_bit;
  logic             next_bit;

`ifdef SHIFT_REG_CTRL_MSB_FIRST_EN
  assign first_bit    = tx_data[WIDTH-1];
  assign shadow_shift = shadow << 1;
  assign next_bit     = shadow_shift[WIDTH-1];
  assign acc_in       = (acc << 1) | WIDTH'(so);
`else
  assign first_bit    = tx_data[0];
  assign shadow_shift = shadow >> 1;
  assign next_bit     = shadow_shift[0];
  assign acc_in       = (acc >> 1) | {so, {(WIDTH-1){1'b0}}};
`endif

  assign tx_ready = (state == IDLE);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    shadow_nxt   = shadow;
    acc_nxt      = acc;
    se_nxt       = se;
    si_nxt       = si;
    rx_valid_nxt = rx_valid;
    rx_data_nxt  = rx_data;
    busy_nxt     = busy;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nxt  = SHIFT;
          shadow_nxt = tx_data;
          count_nxt  = '0;
          acc_nxt    = '0;
          se_nxt     = 1'b1;
          si_nxt     = first_bit;
          busy_nxt   = 1'b1;
        end
      end
      SHIFT: begin
        acc_nxt = acc_in;
        if (count == CNT_W'(WIDTH - 1)) begin
          // Last shift edge: the final so bit goes straight into rx_data.
          state_nxt    = DONE;
          se_nxt       = 1'b0;
          si_nxt       = 1'b0;
          rx_valid_nxt = 1'b1;
          rx_data_nxt  = acc_in;
        end else begin
          count_nxt  = count + CNT_W'(1);
          shadow_nxt = shadow_shift;
          si_nxt     = next_bit;
        end
      end
      DONE: begin
        if (rx_ready) begin
          state_nxt    = IDLE;
          rx_valid_nxt = 1'b0;
          busy_nxt     = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      shadow   <= '0;
      acc      <= '0;
      se       <= 1'b0;
      si       <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      shadow   <= shadow_nxt;
      acc      <= acc_nxt;
      se       <= se_nxt;
      si       <= si_nxt;
      rx_valid <= rx_valid_nxt;
      rx_data  <= rx_data_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Testbench for shift_reg_ctrl with a behavioural serial shift register
// attached (SI enters at the top, SO leaves from bit 0).
module tb_shift_reg_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         si, se, so;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b1;
  logic         busy;

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .si       (si),
    .se       (se),
    .so       (so),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // External shift register, preloaded to zero, not touched by rstn.
  logic [W-1:0] sr = '0;
  always @(posedge clk) if (se) sr <= {si, sr[W-1:1]};
  assign so = sr[0];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int unsigned last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit sent in shift cycle k, from the transmit-order rule.
  function automatic logic exp_si(input logic [W-1:0] w, input int unsigned k);
`ifdef SHIFT_REG_CTRL_MSB_FIRST_EN
    return 1'((w >> (W - 1 - k)) & 1);
`else
    return 1'((w >> k) & 1);
`endif
  endfunction

  // Full transaction starting at a negedge; ends at the negedge where the
  // controller is back in IDLE. exp_period=0 skips the accept-spacing check.
  task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] exp_rx,
                           input bit chk_rx, input int unsigned hold,
                           input int unsigned exp_period);
    int unsigned waited = 0;
    int unsigned acc_cyc;
    tx_data  = w;
    tx_valid = 1'b1;
    rx_ready = (hold == 0);
    while (!tx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      check("tx_ready_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (exp_period != 0) check("accept_period", acc_cyc - last_acc, exp_period);
    last_acc = acc_cyc;
    for (int unsigned k = 0; k < W; k++) begin
      @(negedge clk);
      // Keep tx_valid high with different data: it must be ignored while busy.
      if (k == 0) tx_data = ~w;
      check("shift_se", 32'(se), 32'd1);
      check("shift_si", 32'(si), 32'(exp_si(w, k)));
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_tx_ready", 32'(tx_ready), 32'd0);
      check("shift_rx_valid", 32'(rx_valid), 32'd0);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("done_se", 32'(se), 32'd0);
    check("done_si", 32'(si), 32'd0);
    check("done_rx_valid", 32'(rx_valid), 32'd1);
    check("done_tx_ready", 32'(tx_ready), 32'd0);
    if (chk_rx) check("rx_data", 32'(rx_data), 32'(exp_rx));
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rx_valid", 32'(rx_valid), 32'd1);
      check("hold_se", 32'(se), 32'd0);
      check("hold_tx_ready", 32'(tx_ready), 32'd0);
      if (chk_rx) check("hold_rx_data", 32'(rx_data), 32'(exp_rx));
    end
    rx_ready = 1'b1;
    @(negedge clk);
    check("idle_rx_valid", 32'(rx_valid), 32'd0);
    check("idle_tx_ready", 32'(tx_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] exp_rx;
    int unsigned  hold;
    int unsigned  period;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] prev;
    int unsigned  prev_hold;

    vecs[0] = '{tx: 4'h0, exp_rx: 4'hF, hold: 0,  period: W + 2};
    vecs[1] = '{tx: 4'hB, exp_rx: 4'h0, hold: 0,  period: W + 2};
    vecs[2] = '{tx: 4'hA, exp_rx: 4'hB, hold: 0,  period: W + 2};
    vecs[3] = '{tx: 4'h5, exp_rx: 4'hA, hold: 0,  period: W + 2};
    vecs[4] = '{tx: 4'h3, exp_rx: 4'h5, hold: 0,  period: W + 2};
    vecs[5] = '{tx: 4'hC, exp_rx: 4'h3, hold: 10, period: W + 2};

    // Reset held with a pending word: nothing may be accepted.
    rstn = 1'b0; tx_valid = 1'b1; tx_data = 4'hF; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_se", 32'(se), 32'd0);
    check("rst_si", 32'(si), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    send_word(4'hF, 4'h0, 1'b1, 0, 0);

    foreach (vecs[i]) send_word(vecs[i].tx, vecs[i].exp_rx, 1'b1, vecs[i].hold, vecs[i].period);

    // Randomised traffic: rx word is always the previously sent word.
    prev = 4'hC;
    prev_hold = 10;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] w;
      int unsigned  h;
      w = W'($urandom_range(0, 15));
      h = $urandom_range(0, 3);
      send_word(w, prev, 1'b1, h, W + 2 + prev_hold);
      prev = w;
      prev_hold = h;
    end

    // Reset during the second shift cycle.
    tx_data = 4'h6; tx_valid = 1'b1; rx_ready = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("mid_se_c1", 32'(se), 32'd1);
    @(negedge clk);
    check("mid_se_c2", 32'(se), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_se", 32'(se), 32'd0);
    check("mid_rst_si", 32'(si), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    // Register contents after an aborted shift are unknown: skip that rx word.
    send_word(4'h9, 4'h0, 1'b0, 0, 0);
    send_word(4'hC, 4'h9, 1'b1, 0, W + 2);
    send_word(4'h7, 4'hC, 1'b1, 2, W + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencer for the serial-in/serial-out shift register datapath (SI, SE in; SO out).
- Accepts a parallel word on a valid/ready handshake and serialises it onto SI with SE asserted for exactly WIDTH cycles.
- Samples SO on the same edges, so the word previously held in the register is returned as a parallel rx word on its own valid/ready handshake.
- Sits between a parallel producer/consumer and the shift register instance.

Parameters:
- WIDTH, 4, word width and shift-register depth; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), bit-count register width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- tx_data  input  WIDTH  parallel word to shift in
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  controller can accept a tx word
- si  output  1  serial data to shift register SI
- se  output  1  shift enable to shift register SE
- so  input  1  serial data from shift register SO
- rx_data  output  WIDTH  word shifted out of the register
- rx_valid  output  1  rx_data valid
- rx_ready  input  1  consumer accepts rx_data
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rstn low, asynchronous):
  - State = IDLE.
  - tx_ready=1, se=0, si=0, rx_valid=0, rx_data=0, busy=0.
  - Internal tx shadow and bit counter cleared.
- Outputs se, si, rx_valid, rx_data and busy are registered. tx_ready is combinational from state: it equals (state==IDLE).
- State IDLE:
  - On tx_valid && tx_ready: latch tx_data into the shadow, count=0, go to SHIFT.
  - From the next cycle, se=1 and si = the first bit of the word.
- State SHIFT:
  - se=1 for exactly WIDTH consecutive cycles.
  - In cycle k (k=0..WIDTH-1), si = bit k of the shadow in transmit order.
  - At each rising edge where se=1, the so value is captured into the rx shift accumulator in the same order.
  - count increments each cycle. When count reaches WIDTH-1 at an edge, the next state is DONE; se and si drop to 0 on that transition.
- State DONE:
  - rx_valid=1, rx_data = the accumulated WIDTH bits, held stable while rx_ready=0. se=0, tx_ready=0.
  - On rx_valid && rx_ready: rx_valid drops next cycle and the state returns to IDLE.
- Latency:
  - Accept edge at cycle 0; se high for cycles 1..WIDTH; rx_valid first high in cycle WIDTH+1.
  - Minimum back-to-back period is WIDTH+2 cycles (rx_ready tied high).
- Transmit order: bit 0 first, LSB first (default). The register shifts SI toward SO, so rx_data equals the word written by the previous transaction.
- tx_valid while busy is ignored; the producer holds tx_data and tx_valid until tx_ready.
- rx_ready while rx_valid=0 has no effect.
- Asynchronous reset mid-SHIFT: all outputs return to reset values immediately, including se=0. The partial word is discarded. The external register contents are undefined to the controller.
- Counter never exceeds WIDTH-1. There is no wrap-around path.

Optional Feature:
- Macro: SHIFT_REG_CTRL_MSB_FIRST_EN.
- Defined: transmit order is MSB first. si in SHIFT cycle k = tx bit WIDTH-1-k. Captured so bits fill rx_data from the MSB down.
- Undefined: LSB first, as described in Behaviour.
- Loopback identity (second rx_data equals first tx_data) holds in both builds.

Test Plan:
- Reset check: hold rstn=0 with tx_valid=1 and tx_data=4'hF -> tx_ready=1, se=0, si=0, rx_valid=0, rx_data=0. Release rstn -> word accepted on the first edge; se high for exactly 4 cycles.
- Single word, LSB build, register preloaded to 0: tx_data=4'b1011 -> si sequence 1,1,0,1 on cycles 1..4. rx_valid in cycle 5 with rx_data=4'h0.
- Back-to-back loopback, rx_ready=1: send 4'hA then 4'h5 -> second rx_data=4'hA. Third word 4'h3 returns 4'h5. Period between accepts is 6 cycles.
- Backpressure: rx_ready=0 for 10 cycles in DONE -> rx_valid and rx_data stable, tx_ready=0, se=0. Raise rx_ready -> IDLE one cycle later.
- Reset mid-shift: assert rstn=0 during SHIFT cycle 2 -> se=0 and busy=0 immediately, rx_valid never asserts. After release, the next word completes normally.
- MSB build (SHIFT_REG_CTRL_MSB_FIRST_EN): tx_data=4'b1011 -> si sequence 1,0,1,1. Loopback still returns 4'b1011 on the following transaction.
